// File: rtl/tlb_miss_responder.sv
// tlb_miss_responder: answers micro-TLB refill misses by scanning a software-loaded,
// fully associative backing table LANES entries per cycle. A hit returns the entry,
// a miss in every group returns a one-cycle fault pulse.
module tlb_miss_responder #(
   parameter int unsigned N_ENTRIES = 32,
   parameter int unsigned LANES     = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         miss_req,
   input  logic [51:0]                  miss_vpn,
   output logic                         miss_ready,
   output logic [56:0]                  tlb_rsp,
   output logic                         tlb_rsp_valid,
   output logic                         tlb_fault,
   input  logic                         wr_en,
   input  logic [$clog2(N_ENTRIES)-1:0] wr_idx,
   input  logic [56:0]                  wr_entry,
   input  logic                         inv_all,
   input  logic                         flush,
   output logic                         busy
);

   localparam int unsigned IW = $clog2(N_ENTRIES);
   localparam int unsigned PW = IW + 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SEARCH = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;
   localparam logic [1:0] FAULT  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [51:0]   vpn_q, vpn_d;
   logic [56:0]   rsp_q, rsp_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          fault_q, fault_d;
   logic          busy_q, busy_d;
   logic [56:0]   entries_q [N_ENTRIES];

   logic          hit;
   logic [56:0]   hit_entry;
   logic          last_group;

   assign miss_ready    = (state_q == IDLE) && !flush;
   assign tlb_rsp       = rsp_q;
   assign tlb_rsp_valid = rsp_valid_q;
   assign tlb_fault     = fault_q;
   assign busy          = busy_q;

   // The pointer only ever holds group bases, so the final group starts at N_ENTRIES-LANES.
   assign last_group = (ptr_q >= PW'(N_ENTRIES - LANES));

   // Compare the current group against the registered table; lowest index wins.
   always_comb begin
      logic [IW-1:0] idx;
      hit       = 1'b0;
      hit_entry = '0;
      idx       = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         idx = ptr_q[IW-1:0] + IW'(l);
         if (!hit && entries_q[idx][0] && (entries_q[idx][56:5] == vpn_q)) begin
            hit       = 1'b1;
            hit_entry = entries_q[idx];
         end
      end
   end

   // Next-state and registered-output logic; flush overrides everything.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      vpn_d       = vpn_q;
      rsp_d       = rsp_q;
      rsp_valid_d = 1'b0;
      fault_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (miss_req && miss_ready) begin
               vpn_d   = miss_vpn;
               ptr_d   = '0;
               state_d = SEARCH;
            end
         end
         SEARCH: begin
            if (hit) begin
               rsp_d       = hit_entry;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else if (last_group) begin
               fault_d = 1'b1;
               state_d = FAULT;
            end else begin
               ptr_d = ptr_q + PW'(LANES);
            end
         end
         RESP:    state_d = IDLE;
         FAULT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d     = IDLE;
         rsp_d       = rsp_q;
         rsp_valid_d = 1'b0;
         fault_d     = 1'b0;
      end
      busy_d = (state_d != IDLE);
   end

   // Control and response registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         vpn_q       <= '0;
         rsp_q       <= '0;
         rsp_valid_q <= 1'b0;
         fault_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         vpn_q       <= vpn_d;
         rsp_q       <= rsp_d;
         rsp_valid_q <= rsp_valid_d;
         fault_q     <= fault_d;
         busy_q      <= busy_d;
      end
   end

   // Backing table; invalidate-all beats a same-cycle write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            entries_q[i] <= '0;
         end
      end else if (inv_all) begin
         for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            entries_q[i][0] <= 1'b0;
         end
      end else if (wr_en) begin
         entries_q[wr_idx] <= wr_entry;
      end
   end

endmodule

// File: tb/tb_tlb_miss_responder.sv
// Self-checking bench for tlb_miss_responder: directed scenarios plus randomized
// requests checked against a table model that predicts hit index and latency.
module tb_tlb_miss_responder;

   logic        clk;
   logic        reset;
   logic        miss_req;
   logic [51:0] miss_vpn;
   logic        miss_ready;
   logic [56:0] tlb_rsp;
   logic        tlb_rsp_valid;
   logic        tlb_fault;
   logic        wr_en;
   logic [4:0]  wr_idx;
   logic [56:0] wr_entry;
   logic        inv_all;
   logic        flush;
   logic        busy;

   int          checks;
   int          fails;
   logic [56:0] tbl [32];
   logic [56:0] held;

   tlb_miss_responder #(.N_ENTRIES(32), .LANES(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .miss_req      (miss_req),
      .miss_vpn      (miss_vpn),
      .miss_ready    (miss_ready),
      .tlb_rsp       (tlb_rsp),
      .tlb_rsp_valid (tlb_rsp_valid),
      .tlb_fault     (tlb_fault),
      .wr_en         (wr_en),
      .wr_idx        (wr_idx),
      .wr_entry      (wr_entry),
      .inv_all       (inv_all),
      .flush         (flush),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [56:0] mk(input logic [51:0] vpn, input logic [3:0] attr,
                                      input logic v);
      return {vpn, attr, v};
   endfunction

   // Lowest valid index holding vpn, or -1.
   function automatic int find(input logic [51:0] vpn);
      for (int i = 0; i < 32; i++) begin
         if (tbl[i][0] && tbl[i][56:5] == vpn) return i;
      end
      return -1;
   endfunction

   task automatic write_entry(input logic [4:0] idx, input logic [56:0] e);
      wr_en    = 1'b1;
      wr_idx   = idx;
      wr_entry = e;
      tick();
      wr_en    = 1'b0;
      tbl[idx] = e;
   endtask

   task automatic clear_model;
      for (int i = 0; i < 32; i++) tbl[i][0] = 1'b0;
   endtask

   // Issue one request; optionally write (or invalidate) before edge wr_at after accept.
   // lat counts edges after the accept edge to the first pulse; 0 means no pulse arrived.
   task automatic run_req(input logic [51:0] vpn, input int wr_at, input bit winv,
                          input logic [4:0] widx, input logic [56:0] went,
                          output int wait_cyc, output int lat, output logic [56:0] rsp,
                          output bit got_fault, output bit both);
      wait_cyc  = 0;
      lat       = 0;
      rsp       = '0;
      got_fault = 1'b0;
      both      = 1'b0;
      while (!miss_ready && wait_cyc < 10) begin
         tick();
         wait_cyc++;
      end
      miss_req = 1'b1;
      miss_vpn = vpn;
      tick();
      miss_req = 1'b0;
      for (int n = 1; n <= 14; n++) begin
         if (n == wr_at) begin
            if (winv) begin
               inv_all = 1'b1;
            end else begin
               wr_en    = 1'b1;
               wr_idx   = widx;
               wr_entry = went;
            end
         end
         tick();
         wr_en   = 1'b0;
         inv_all = 1'b0;
         if (tlb_rsp_valid && tlb_fault) both = 1'b1;
         if (tlb_rsp_valid || tlb_fault) begin
            lat       = n;
            rsp       = tlb_rsp;
            got_fault = tlb_fault;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      #3;
      checks++; if (miss_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", miss_ready); end
      checks++; if (tlb_rsp !== 57'd0) begin fails++; $display("FAIL reset_rsp got %h want 0", tlb_rsp); end
      checks++; if (tlb_rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", tlb_rsp_valid); end
      checks++; if (tlb_fault !== 1'b0) begin fails++; $display("FAIL reset_fault got %b want 0", tlb_fault); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      flush = 1'b1;
      #1;
      checks++; if (miss_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_flush got %b want 0", miss_ready); end
      flush = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      held  = '0;
      for (int i = 0; i < 32; i++) tbl[i] = '0;
      tick();
   endtask

   task automatic test_basic_hit;
      int w, lat; logic [56:0] rsp; bit f, both;
      write_entry(5'd5, mk(52'h12345, 4'hA, 1'b1));
      run_req(52'h12345, 0, 1'b0, 5'd0, '0, w, lat, rsp, f, both);
      checks++; if (lat !== 2) begin fails++; $display("FAIL hit5_latency got %0d want 2", lat); end
      checks++; if (f !== 1'b0) begin fails++; $display("FAIL hit5_fault got %b want 0", f); end
      checks++; if (rsp !== mk(52'h12345, 4'hA, 1'b1)) begin fails++; $display("FAIL hit5_rsp got %h want %h", rsp, mk(52'h12345, 4'hA, 1'b1)); end
      checks++; if (both !== 1'b0) begin fails++; $display("FAIL hit5_both got %b want 0", both); end
      held = mk(52'h12345, 4'hA, 1'b1);
   endtask

   task automatic test_fault_back_to_back;
      int w, lat; logic [56:0] rsp; bit f, both;
      run_req(52'h777, 0, 1'b0, 5'd0, '0, w, lat, rsp, f, both);
      checks++; if (lat !== 8) begin fails++; $display("FAIL miss_latency got %0d want 8", lat); end
      checks++; if (f !== 1'b1) begin fails++; $display("FAIL miss_fault got %b want 1", f); end
      checks++; if (rsp !== held) begin fails++; $display("FAIL miss_rsp_held got %h want %h", rsp, held); end
      checks++; if (both !== 1'b0) begin fails++; $display("FAIL miss_both got %b want 0", both); end
      run_req(52'h12345, 0, 1'b0, 5'd0, '0, w, lat, rsp, f, both);
      checks++; if (w !== 1) begin fails++; $display("FAIL b2b_wait got %0d want 1", w); end
      checks++; if (lat !== 2 || f !== 1'b0) begin fails++; $display("FAIL b2b_hit got lat %0d fault %b want lat 2 fault 0", lat, f); end
   endtask

   task automatic test_duplicate;
      int w, lat; logic [56:0] rsp; bit f, both;
      write_entry(5'd9, mk(52'hABCDE, 4'h3, 1'b1));
      write_entry(5'd10, mk(52'hABCDE, 4'hC, 1'b1));
      run_req(52'hABCDE, 0, 1'b0, 5'd0, '0, w, lat, rsp, f, both);
      checks++; if (lat !== 3) begin fails++; $display("FAIL dup_latency got %0d want 3", lat); end
      checks++; if (rsp !== mk(52'hABCDE, 4'h3, 1'b1)) begin fails++; $display("FAIL dup_rsp got %h want %h", rsp, mk(52'hABCDE, 4'h3, 1'b1)); end
      held = mk(52'hABCDE, 4'h3, 1'b1);
   endtask

   task automatic test_flush;
      int pulses, w;
      write_entry(5'd30, mk(52'h30303, 4'h6, 1'b1));
      for (int c = 0; c < 2; c++) begin
         logic [51:0] vpn;
         int fat;
         vpn    = (c == 0) ? 52'h30303 : 52'h12345;
         fat    = (c == 0) ? 3 : 2;
         pulses = 0;
         w      = 0;
         while (!miss_ready && w < 10) begin tick(); w++; end
         miss_req = 1'b1;
         miss_vpn = vpn;
         tick();
         miss_req = 1'b0;
         for (int n = 1; n <= 12; n++) begin
            if (n == fat) flush = 1'b1;
            tick();
            flush = 1'b0;
            if (tlb_rsp_valid || tlb_fault) pulses++;
            if (n == fat) begin
               checks++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy case %0d got %b want 0", c, busy); end
            end
         end
         checks++; if (pulses !== 0) begin fails++; $display("FAIL flush_pulses case %0d got %0d want 0", c, pulses); end
      end
      flush = 1'b1;
      #1;
      checks++; if (miss_ready !== 1'b0) begin fails++; $display("FAIL idle_flush_ready got %b want 0", miss_ready); end
      flush = 1'b0;
      #1;
      checks++; if (miss_ready !== 1'b1) begin fails++; $display("FAIL idle_ready got %b want 1", miss_ready); end
   endtask

   task automatic test_inv_all;
      int w, lat; logic [56:0] rsp; bit f, both;
      inv_all  = 1'b1;
      wr_en    = 1'b1;
      wr_idx   = 5'd2;
      wr_entry = mk(52'hD00D, 4'h5, 1'b1);
      tick();
      inv_all = 1'b0;
      wr_en   = 1'b0;
      clear_model();
      run_req(52'hD00D, 0, 1'b0, 5'd0, '0, w, lat, rsp, f, both);
      checks++; if (f !== 1'b1 || lat !== 8) begin fails++; $display("FAIL inv_drop_write got fault %b lat %0d want fault 1 lat 8", f, lat); end
      run_req(52'h12345, 0, 1'b0, 5'd0, '0, w, lat, rsp, f, both);
      checks++; if (f !== 1'b1) begin fails++; $display("FAIL inv_cleared got fault %b want 1", f); end
   endtask

   task automatic test_write_during_search;
      int w, lat; logic [56:0] rsp; bit f, both;
      run_req(52'h28282, 1, 1'b0, 5'd28, mk(52'h28282, 4'h9, 1'b1), w, lat, rsp, f, both);
      tbl[28] = mk(52'h28282, 4'h9, 1'b1);
      checks++; if (lat !== 8 || f !== 1'b0) begin fails++; $display("FAIL wr28_hit got lat %0d fault %b want lat 8 fault 0", lat, f); end
      checks++; if (rsp !== mk(52'h28282, 4'h9, 1'b1)) begin fails++; $display("FAIL wr28_rsp got %h want %h", rsp, mk(52'h28282, 4'h9, 1'b1)); end
      held = mk(52'h28282, 4'h9, 1'b1);
      run_req(52'h00BEE, 4, 1'b0, 5'd0, mk(52'h00BEE, 4'h1, 1'b1), w, lat, rsp, f, both);
      tbl[0] = mk(52'h00BEE, 4'h1, 1'b1);
      checks++; if (lat !== 8 || f !== 1'b1) begin fails++; $display("FAIL wr0_late got lat %0d fault %b want lat 8 fault 1", lat, f); end
      run_req(52'h00BEE, 0, 1'b0, 5'd0, '0, w, lat, rsp, f, both);
      checks++; if (lat !== 1 || rsp !== tbl[0]) begin fails++; $display("FAIL wr0_visible got lat %0d rsp %h want lat 1 rsp %h", lat, rsp, tbl[0]); end
      held = tbl[0];
      run_req(52'h28282, 2, 1'b1, 5'd0, '0, w, lat, rsp, f, both);
      clear_model();
      checks++; if (lat !== 8 || f !== 1'b1) begin fails++; $display("FAIL inv_mid_search got lat %0d fault %b want lat 8 fault 1", lat, f); end
   endtask

   task automatic test_random;
      logic [51:0] pool [6];
      int w, lat, ei, elat; logic [56:0] rsp; bit f, both;
      logic [51:0] vpn;
      for (int i = 0; i < 6; i++) pool[i] = {20'($urandom), $urandom};
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 9) == 0) begin
            inv_all = 1'b1;
            tick();
            inv_all = 1'b0;
            clear_model();
         end
         for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
            write_entry(5'($urandom_range(0, 31)),
                        mk(pool[$urandom_range(0, 5)], 4'($urandom), $urandom_range(0, 3) != 0));
         end
         vpn = ($urandom_range(0, 4) == 0) ? {20'($urandom), $urandom} : pool[$urandom_range(0, 5)];
         ei   = find(vpn);
         elat = (ei < 0) ? 8 : ei / 4 + 1;
         run_req(vpn, 0, 1'b0, 5'd0, '0, w, lat, rsp, f, both);
         checks++; if (lat !== elat) begin fails++; $display("FAIL rand_latency it %0d got %0d want %0d", it, lat, elat); end
         checks++; if (f !== (ei < 0)) begin fails++; $display("FAIL rand_fault it %0d got %b want %b", it, f, ei < 0); end
         if (ei >= 0) held = tbl[ei];
         checks++; if (rsp !== held) begin fails++; $display("FAIL rand_rsp it %0d got %h want %h", it, rsp, held); end
         checks++; if (both !== 1'b0) begin fails++; $display("FAIL rand_both it %0d got %b want 0", it, both); end
      end
   endtask

   task automatic test_reset_mid_search;
      int w, lat, pulses; logic [56:0] rsp; bit f, both;
      write_entry(5'd28, mk(52'hE0E0E, 4'h2, 1'b1));
      w = 0;
      while (!miss_ready && w < 10) begin tick(); w++; end
      miss_req = 1'b1;
      miss_vpn = 52'hE0E0E;
      tick();
      miss_req = 1'b0;
      tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", busy); end
      checks++; if (tlb_rsp !== 57'd0) begin fails++; $display("FAIL rst_mid_rsp got %h want 0", tlb_rsp); end
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 32; i++) tbl[i] = '0;
      held   = '0;
      pulses = 0;
      for (int n = 0; n < 12; n++) begin
         tick();
         if (tlb_rsp_valid || tlb_fault) pulses++;
      end
      checks++; if (pulses !== 0) begin fails++; $display("FAIL rst_mid_pulses got %0d want 0", pulses); end
      run_req(52'hE0E0E, 0, 1'b0, 5'd0, '0, w, lat, rsp, f, both);
      checks++; if (f !== 1'b1 || lat !== 8) begin fails++; $display("FAIL rst_table_cleared got fault %b lat %0d want fault 1 lat 8", f, lat); end
   endtask

   initial begin
      checks   = 0;
      fails    = 0;
      reset    = 1'b0;
      miss_req = 1'b0;
      miss_vpn = '0;
      wr_en    = 1'b0;
      wr_idx   = '0;
      wr_entry = '0;
      inv_all  = 1'b0;
      flush    = 1'b0;
      test_reset();
      test_basic_hit();
      test_fault_back_to_back();
      test_duplicate();
      test_flush();
      test_inv_all();
      test_write_during_search();
      test_random();
      test_reset_mid_search();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/tlb_miss_responder.md
# tlb_miss_responder

Responder side of the micro-TLB refill interface. It accepts a miss request (VPN) from an I- or D-side micro-TLB and searches a software-loaded, fully associative backing table several entries per cycle. It then returns either a 57-bit entry on `tlb_rsp`/`tlb_rsp_valid` or a one-cycle fault pulse. It sits between the micro-TLBs and the CP0 TLB-write path.

## Interface
- `N_ENTRIES`, 32: backing-table depth; power of 2, multiple of `LANES`.
- `LANES`, 4: entries compared per search cycle; power of 2.
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-low reset.
- `miss_req`  in  1: miss request valid.
- `miss_vpn`  in  52: virtual page number, addr[63:12].
- `miss_ready`  out  1: request accepted when `miss_req & miss_ready`.
- `tlb_rsp`  out  57: entry: [56:5] VPN, [4:1] attributes, [0] valid.
- `tlb_rsp_valid`  out  1: one-cycle pulse, `tlb_rsp` valid.
- `tlb_fault`  out  1: one-cycle pulse, no matching entry.
- `wr_en`  in  1: table write.
- `wr_idx`  in  log2(N_ENTRIES): write index.
- `wr_entry`  in  57: written entry, same format as `tlb_rsp`.
- `inv_all`  in  1: clear all table valid bits.
- `flush`  in  1: abort the in-flight search.
- `busy`  out  1: state != IDLE.

## Operation
- Table: `N_ENTRIES` × 57-bit registers. An entry matches when bit[0]=1 and [56:5]==latched VPN.
- FSM states: IDLE, SEARCH, RESP, FAULT.
- IDLE:
  - `miss_ready = !flush`.
  - On accept: latch `miss_vpn`, set scan pointer `ptr=0`, go to SEARCH.
- SEARCH: compare entries `ptr .. ptr+LANES-1` against live table contents.
  - Any match: the lowest index wins; register that entry into `tlb_rsp`; go to RESP.
  - No match, `ptr+LANES < N_ENTRIES`: `ptr += LANES`.
  - No match in the last group: go to FAULT.
  - `ptr` width is log2(N_ENTRIES)+1. `ptr` never wraps.
- RESP: `tlb_rsp_valid=1` for exactly one cycle, then go to IDLE.
- FAULT: `tlb_fault=1` for exactly one cycle. `tlb_rsp` is held, `tlb_rsp_valid=0`. Then go to IDLE.
- `tlb_rsp_valid` and `tlb_fault` are never both 1.
- `flush`:
  - In any state, next state is IDLE.
  - No `tlb_rsp_valid` or `tlb_fault` is produced for the aborted request, including when `flush` coincides with the RESP or FAULT cycle.
  - Holds `miss_ready=0` in the same cycle.
- `wr_en`:
  - Accepted in any state; `entries[wr_idx] <= wr_entry` at the clock edge.
  - Visible to SEARCH from the next cycle on. Groups already scanned are not rescanned.
- `inv_all`:
  - Clears bit[0] of every entry at the edge.
  - Takes priority over a same-cycle `wr_en`, whose write is dropped.
  - Does not abort a search; the remaining groups see the cleared valid bits.
- A write in the same cycle as a SEARCH compare of that index: the compare uses the pre-write value.

## Timing
- Reset (`reset`=0, asynchronous):
  - State IDLE, `ptr`=0, latched VPN 0.
  - `tlb_rsp`=0, `tlb_rsp_valid`=0, `tlb_fault`=0, `busy`=0.
  - All entries zeroed (valid=0).
  - `miss_ready` follows IDLE & !flush, so it is 1 while in reset with `flush`=0.
- Reset asserted mid-search: immediate return to IDLE; no response is ever issued for that request.
- Request accepted at edge T, hit in group g (g = index / LANES): `tlb_rsp_valid` high during cycle T+2+g.
- Miss: `tlb_fault` high during cycle T+1+N_ENTRIES/LANES.
- Back-to-back: the next request can be accepted in the cycle after the RESP/FAULT pulse. Minimum spacing between accepts is 3 cycles.
- All outputs except `miss_ready` are registered.

## Test plan
- Reset, then `wr_en` idx 5 with VPN 0x12345, attrs 0xA, valid. Request VPN 0x12345 at T → `tlb_rsp_valid` at T+3, `tlb_rsp`=={0x12345,0xA,1}.
- Request an absent VPN 0x777 with defaults → `tlb_fault` at T+9, `tlb_rsp_valid` stays 0. Follow with the idx-5 request → hit at T'+3.
- Duplicate VPN at idx 9 and idx 10 with different attrs → response carries the idx-9 attrs, at T+4.
- Request VPN at idx 30, `flush` at T+3 → no pulse on either output; `busy`=0 at T+4.
- `inv_all` and `wr_en` to idx 2 in the same cycle, then request that VPN → `tlb_fault`.
- Write VPN into idx 28 during group-0 SEARCH → hit at T+2+7. Write into idx 0 during group-3 SEARCH → fault.
